e_mdu_ctrl: RTL and testbench

// - E-stage multiply/divide sequencer: accepts MDU ops with E-stage operands (post data2 mux), models fixed

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/e_mdu_arith.sv | 58 +++++
 rtl/e_mdu_ctrl.sv | 110 +++++++++++
 tb/tb_e_mdu_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes, FSM states, arith result.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MFHI  = 3'd6;
  localparam logic [2:0] MDU_MFLO  = 3'd7;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } arith_res_t;

  // Multi-cycle ops (mult/div family) all sit in the lower half of the op space.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational MDU datapath: (op, a, b) -> {hi, lo, div0}. Non-arith ops yield zero.
module e_mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output arith_res_t  res
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div0;
  logic               ovf;
  logic [31:0]        b_safe;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign div0   = (b == 32'd0);
  assign ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  // Never hand the divider a zero or the overflowing pair; those cases are patched below.
  assign b_safe = (div0 || ovf) ? 32'd1 : b;
  assign sa     = a;
  assign sb     = b_safe;
  assign quot_s = sa / sb;
  assign rem_s  = sa % sb;

  always_comb begin
    res = '0;
    case (op)
      MDU_MULT:  {res.hi, res.lo} = prod_s;
      MDU_MULTU: {res.hi, res.lo} = prod_u;
      MDU_DIV: begin
        res.div0 = div0;
        if (ovf) begin
          res.lo = 32'h8000_0000;
          res.hi = 32'd0;
        end else begin
          res.lo = quot_s;
          res.hi = rem_s;
        end
      end
      MDU_DIVU: begin
        res.div0 = div0;
        res.lo   = a / b_safe;
        res.hi   = a % b_safe;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage MDU sequencer: fixed-latency mult/div, HI/LO ownership, D-stage stall request.
// Optional macro MDU_PERF_CNT_EN adds md_stall_cnt, a count of stalled cycles.
module e_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_mdu_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_is_md,
  output logic        E_busy,
  output logic        D_stall_md,
  output logic [31:0] E_mdu_out,
  output logic [31:0] HI,
  output logic [31:0] LO
`ifdef MDU_PERF_CNT_EN
  ,
  output logic [31:0] md_stall_cnt
`endif
);

  mdu_state_e  state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic        load, commit;
  logic        start_md;
  arith_res_t  arith, pend;
  logic [31:0] hi_q, lo_q;

  e_mdu_arith u_arith (
    .op  (E_mdu_op),
    .a   (E_A),
    .b   (E_B),
    .res (arith)
  );

  assign start_md = E_start && is_md_op(E_mdu_op);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (start_md) begin
        state_nxt = BUSY;
        load      = 1'b1;
        cnt_nxt   = is_div_op(E_mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) pend <= arith;
      // A divide by zero still burns the full latency but leaves HI/LO alone.
      if (commit) begin
        if (!pend.div0) begin
          hi_q <= pend.hi;
          lo_q <= pend.lo;
        end
      end else if (state == IDLE && E_start) begin
        if (E_mdu_op == MDU_MTHI) hi_q <= E_A;
        if (E_mdu_op == MDU_MTLO) lo_q <= E_A;
      end
    end
  end

  assign E_busy     = (state == BUSY);
  assign D_stall_md = D_is_md && (E_busy || start_md);
  assign HI         = hi_q;
  assign LO         = lo_q;

  always_comb begin
    case (E_mdu_op)
      MDU_MFHI: E_mdu_out = hi_q;
      MDU_MFLO: E_mdu_out = lo_q;
      default:  E_mdu_out = 32'd0;
    endcase
  end

`ifdef MDU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)          md_stall_cnt <= '0;
    else if (D_stall_md) md_stall_cnt <= md_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Bench for e_mdu_ctrl: directed ops against a cycle-count/arithmetic model, plus literal pins.
module tb_e_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        E_start = 1'b0;
  logic [2:0]  E_mdu_op = 3'd0;
  logic [31:0] E_A = 32'd0;
  logic [31:0] E_B = 32'd0;
  logic        D_is_md = 1'b0;
  logic        E_busy, D_stall_md;
  logic [31:0] E_mdu_out, HI, LO;

  int checks = 0;
  int errors = 0;

  e_mdu_ctrl dut (
    .clk(clk), .reset(reset), .E_start(E_start), .E_mdu_op(E_mdu_op),
    .E_A(E_A), .E_B(E_B), .D_is_md(D_is_md), .E_busy(E_busy),
    .D_stall_md(D_stall_md), .E_mdu_out(E_mdu_out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on wide integers: {div0, hi, lo}.
  function automatic logic [64:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp, q, r;
    longint unsigned up;
    case (op)
      3'd0: begin sp = longint'(int'(a)) * longint'(int'(b)); return {1'b0, sp[63:0]}; end
      3'd1: begin up = longint'(a) * longint'(b); return {1'b0, up[63:0]}; end
      3'd2: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        q = longint'(int'(a)) / longint'(int'(b));
        r = longint'(int'(a)) % longint'(int'(b));
        return {1'b0, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        return {1'b0, a % b, a / b};
      end
      default: return 65'd0;
    endcase
  endfunction

  // Model: busy from the accepting edge until edge m_end, when the result lands.
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic        p_div0 = 0, m_busy = 0, mvalid = 0;
  int          edge_no = 0, m_end = 0;

  always @(posedge clk) begin
    edge_no <= edge_no + 1;
    if (!reset) begin
      m_hi <= 0; m_lo <= 0; m_busy <= 0; mvalid <= 1'b1;
    end else if (m_busy) begin
      if (edge_no == m_end) begin
        m_busy <= 1'b0;
        if (!p_div0) begin m_hi <= p_hi; m_lo <= p_lo; end
      end
    end else if (E_start) begin
      if (E_mdu_op < 3'd4) begin
        {p_div0, p_hi, p_lo} <= calc(E_mdu_op, E_A, E_B);
        m_busy <= 1'b1;
        m_end  <= edge_no + ((E_mdu_op >= 3'd2) ? 10 : 5);
      end else if (E_mdu_op == 3'd4) m_hi <= E_A;
      else if (E_mdu_op == 3'd5) m_lo <= E_A;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_busy", {31'd0, E_busy}, {31'd0, m_busy});
      chk("m_stall", {31'd0, D_stall_md},
          {31'd0, D_is_md && (m_busy || (E_start && E_mdu_op < 3'd4))});
      chk("m_out", E_mdu_out, (E_mdu_op == 3'd6) ? m_hi : (E_mdu_op == 3'd7) ? m_lo : 32'd0);
      chk("m_hi", HI, m_hi);
      chk("m_lo", LO, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue a mult/div, check busy/stall for n cycles with HI/LO held, then the commit.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic dmd, input logic [31:0] ph, input logic [31:0] pl,
                        input logic [31:0] eh, input logic [31:0] el);
    E_start = 1; E_mdu_op = op; E_A = a; E_B = b; D_is_md = dmd;
    #1;
    chk({nm, "_stall_start"}, {31'd0, D_stall_md}, {31'd0, dmd});
    tick();
    E_start = 0; E_mdu_op = 3'd0;
    #1;
    for (int i = 0; i < n; i++) begin
      chk({nm, "_busy"}, {31'd0, E_busy}, 32'd1);
      chk({nm, "_stall"}, {31'd0, D_stall_md}, {31'd0, dmd});
      chk({nm, "_hold_hi"}, HI, ph);
      chk({nm, "_hold_lo"}, LO, pl);
      tick();
    end
    chk({nm, "_done"}, {31'd0, E_busy}, 32'd0);
    chk({nm, "_stall_off"}, {31'd0, D_stall_md}, 32'd0);
    chk({nm, "_hi"}, HI, eh);
    chk({nm, "_lo"}, LO, el);
    D_is_md = 0;
  endtask

  initial begin
    reset = 0;
    tick(); tick();
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, E_busy}, 32'd0);
    chk("rst_stall", {31'd0, D_stall_md}, 32'd0);
    reset = 1;
    tick();

    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    chk("model_mult_hi", m_hi, 32'hFFFF_FFFF);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd1, 32'hFFFF_FFFE);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 1'b1, 32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    chk("model_div_lo", m_lo, 32'hFFFF_FFFD);
    run_op("divu0", 3'd3, 32'd7, 32'd0, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'd0, 32'h8000_0000);
    chk("model_ovf_lo", m_lo, 32'h8000_0000);
    run_op("multneg", 3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5, 1'b0, 32'd0, 32'h8000_0000, 32'd0, 32'd15);
    run_op("divu", 3'd3, 32'd100, 32'd7, 10, 1'b0, 32'd0, 32'd15, 32'd2, 32'd14);

    // MTHI then MFHI/MFLO
    E_start = 1; E_mdu_op = 3'd4; E_A = 32'h1234;
    tick();
    E_mdu_op = 3'd6; E_A = 0;
    #1;
    chk("mfhi", E_mdu_out, 32'h1234);
    E_mdu_op = 3'd7;
    #1;
    chk("mflo_prior", E_mdu_out, 32'd14);
    E_mdu_op = 3'd5; E_A = 32'hCAFE;
    tick();
    E_mdu_op = 3'd7;
    #1;
    chk("mtlo_mflo", E_mdu_out, 32'hCAFE);
    E_mdu_op = 3'd2;
    #1;
    chk("out_zero_other_op", E_mdu_out, 32'd0);
    E_start = 0; E_mdu_op = 0;
    tick();

    // E_start while busy is ignored
    E_start = 1; E_mdu_op = 3'd0; E_A = 32'd3; E_B = 32'd4;
    tick();
    E_start = 0;
    tick();
    E_start = 1; E_mdu_op = 3'd4; E_A = 32'hDEAD;
    tick();
    E_start = 1; E_mdu_op = 3'd1; E_A = 32'd9; E_B = 32'd9;
    tick();
    E_start = 0; E_mdu_op = 0;
    tick(); tick();
    chk("ign_busy_done", {31'd0, E_busy}, 32'd0);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd12);

    // Reset during busy cycle 3 of a MULT
    E_start = 1; E_mdu_op = 3'd0; E_A = 32'd5; E_B = 32'd5;
    tick();
    E_start = 0;
    tick(); tick();
    chk("pre_rst_busy", {31'd0, E_busy}, 32'd1);
    reset = 0;
    tick();
    reset = 1;
    chk("midrst_busy", {31'd0, E_busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    repeat (8) tick();
    chk("midrst_nocommit_hi", HI, 32'd0);
    chk("midrst_nocommit_lo", LO, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
